// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
//   Shared definitions for the MEM pipeline stage: load/store opcode
//   constants, the access-width enum, the extension-type enum and the
//   small decode helpers used to turn an opcode into width/extension.
package memory_stage_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_LB  = 6'b100000;
  localparam logic [OPCODE_W-1:0] OP_LH  = 6'b100001;
  localparam logic [OPCODE_W-1:0] OP_LW  = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_LBU = 6'b100100;
  localparam logic [OPCODE_W-1:0] OP_LHU = 6'b100101;
  localparam logic [OPCODE_W-1:0] OP_SB  = 6'b101000;
  localparam logic [OPCODE_W-1:0] OP_SH  = 6'b101001;
  localparam logic [OPCODE_W-1:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ACC_BYTE = 2'd0,
    ACC_HALF = 2'd1,
    ACC_WORD = 2'd2
  } access_t;

  typedef enum logic {
    EXT_ZERO = 1'b0,
    EXT_SIGN = 1'b1
  } ext_t;

  // Width is a property of the opcode alone; anything unrecognised is a word.
  function automatic access_t decode_access(input logic [OPCODE_W-1:0] op);
    access_t acc;
    case (op)
      OP_LB, OP_LBU, OP_SB: acc = ACC_BYTE;
      OP_LH, OP_LHU, OP_SH: acc = ACC_HALF;
      default:              acc = ACC_WORD;
    endcase
    return acc;
  endfunction

  function automatic ext_t decode_ext(input logic [OPCODE_W-1:0] op);
    ext_t ext;
    case (op)
      OP_LB, OP_LH: ext = EXT_SIGN;
      default:      ext = EXT_ZERO;
    endcase
    return ext;
  endfunction

  function automatic logic is_misaligned(input access_t acc, input logic [1:0] low);
    logic mis;
    case (acc)
      ACC_BYTE: mis = 1'b0;
      ACC_HALF: mis = low[0];
      default:  mis = (low != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_stage_data_memory.sv
// data_memory
//   Word-organised data array with per-byte write enables.
//   Ports:
//     clk, rst_n        clock / asynchronous active-low clear of every word
//     byte_en           one enable per byte lane; lane k = bits [8k+7:8k]
//     addr              word address shared by the write and the read port
//     wdata             write data, already replicated into the active lanes
//     rdata             combinational read of mem[addr]
//     debug_addr        word address for the debug port
//     debug_data        combinational read of mem[debug_addr]
module data_memory #(
  parameter int NB       = 32,
  parameter int NB_WADDR = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NB/8-1:0]     byte_en,
  input  logic [NB_WADDR-1:0] addr,
  input  logic [NB-1:0]       wdata,
  output logic [NB-1:0]       rdata,
  input  logic [NB_WADDR-1:0] debug_addr,
  output logic [NB-1:0]       debug_data
);

  localparam int DEPTH = 1 << NB_WADDR;

  logic [NB-1:0] mem [DEPTH];

  // Reset clears the whole array so a reset arriving mid-store leaves no
  // partially written word behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else begin
      for (int l = 0; l < NB/8; l++) begin
        if (byte_en[l]) begin
          mem[addr][l*8 +: 8] <= wdata[l*8 +: 8];
        end
      end
    end
  end

  assign rdata      = mem[addr];
  assign debug_data = mem[debug_addr];

endmodule

// File: rtl/memory_stage.sv
// memory_stage
//   MEM pipeline stage: byte/halfword/word loads and stores against a local
//   data memory, with sign/zero extension and misalignment detection, results
//   registered into the MEM/WB boundary.
//   Ports:
//     i_clk, i_reset_n    clock / asynchronous active-low reset
//     i_valid             instruction present this cycle
//     i_mem_read          load request
//     i_mem_write         store request (wins over a simultaneous load)
//     i_op_code           selects access width and extension
//     i_alu_result        effective byte address (low NB_ADDR bits decoded)
//     i_data_b            store data, low bytes used for SB/SH
//     i_debug_addr        debug word address
//     o_debug_data        combinational word at i_debug_addr
//     o_valid             registered i_valid
//     o_read_data         registered extended load data (0 when no load)
//     o_alu_result        registered i_alu_result
//     o_misaligned        registered misaligned-access flag
//
//   Handshake: there is no ready. i_valid qualifies every other input in the
//   cycle it is high and the stage always accepts it; upstream gates bubbles
//   by driving i_valid low. o_valid is i_valid delayed by one edge.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int NB        = 32,
  parameter int NB_OPCODE = 6,
  parameter int NB_ADDR   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_valid,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic [NB_OPCODE-1:0] i_op_code,
  input  logic [NB-1:0]        i_alu_result,
  input  logic [NB-1:0]        i_data_b,
  input  logic [NB_ADDR-3:0]   i_debug_addr,
  output logic [NB-1:0]        o_debug_data,
  output logic                 o_valid,
  output logic [NB-1:0]        o_read_data,
  output logic [NB-1:0]        o_alu_result,
  output logic                 o_misaligned
);

  localparam int NB_LANES = NB / 8;

  logic [NB_ADDR-1:0]  addr;
  logic [1:0]          lane;
  access_t             acc;
  ext_t                ext;
  logic                mis_raw;
  logic                is_access;
  logic                misaligned;
  logic                do_store;
  logic                do_load;
  logic [NB_LANES-1:0] byte_en;
  logic [NB-1:0]       wdata;
  logic [NB-1:0]       rdata;
  logic [NB-1:0]       shifted;
  logic [NB-1:0]       load_data;

  // Upper address bits are ignored: accesses simply wrap within the array.
  assign addr = i_alu_result[NB_ADDR-1:0];
  assign lane = addr[1:0];
  assign acc  = decode_access(i_op_code);
  assign ext  = decode_ext(i_op_code);

  assign mis_raw    = is_misaligned(acc, lane);
  assign is_access  = i_valid & (i_mem_read | i_mem_write);
  assign misaligned = is_access & mis_raw;
  assign do_store   = i_valid & i_mem_write & ~mis_raw;
  // A store in the same slot takes priority, so the load side stays silent.
  assign do_load    = i_valid & i_mem_read & ~i_mem_write & ~mis_raw;

  // Store lane steering: data is replicated into every lane and the byte
  // enables pick which lanes actually commit.
  always_comb begin
    byte_en = '0;
    wdata   = '0;
    case (acc)
      ACC_BYTE: begin
        byte_en = 4'b0001 << lane;
        wdata   = {NB_LANES{i_data_b[7:0]}};
      end
      ACC_HALF: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wdata   = {(NB_LANES/2){i_data_b[15:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wdata   = i_data_b;
      end
    endcase
    if (!do_store) begin
      byte_en = '0;
    end
  end

  data_memory #(
    .NB       (NB),
    .NB_WADDR (NB_ADDR - 2)
  ) u_data_memory (
    .clk        (i_clk),
    .rst_n      (i_reset_n),
    .byte_en    (byte_en),
    .addr       (addr[NB_ADDR-1:2]),
    .wdata      (wdata),
    .rdata      (rdata),
    .debug_addr (i_debug_addr),
    .debug_data (o_debug_data)
  );

  // Bring the addressed lane down to bit 0, then extend.
  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    load_data = '0;
    case (acc)
      ACC_BYTE: begin
        if (ext == EXT_SIGN) load_data = {{(NB-8){shifted[7]}}, shifted[7:0]};
        else                 load_data = {{(NB-8){1'b0}}, shifted[7:0]};
      end
      ACC_HALF: begin
        if (ext == EXT_SIGN) load_data = {{(NB-16){shifted[15]}}, shifted[15:0]};
        else                 load_data = {{(NB-16){1'b0}}, shifted[15:0]};
      end
      default: load_data = rdata;
    endcase
    if (!do_load) begin
      load_data = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid      <= 1'b0;
      o_read_data  <= '0;
      o_alu_result <= '0;
      o_misaligned <= 1'b0;
    end else begin
      o_valid      <= i_valid;
      o_read_data  <= load_data;
      o_alu_result <= i_alu_result;
      o_misaligned <= misaligned;
    end
  end

endmodule
